// File: rtl/muldiv_unit_if.sv
// Issue/write-back interface between the core and the iterative multiply/divide unit.
// Issue side: start/op/operands/rd_in.
// Return side: busy/done/result/rd_sel/reg_write/illegal.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_sel;
  logic            reg_write;
  logic            illegal;

  // Core / issue side
  modport master (
    output start, op, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_sel, reg_write, illegal
  );

  // Execution unit side
  modport slave (
    input  start, op, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_sel, reg_write, illegal
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add / shift-subtract step per cycle.
// Latency: XLEN+1 edges from accept to done for normal ops, 1 edge for special/illegal divides.
// Backpressure: start is taken only in IDLE; a new op can be presented during the done cycle.
// Optional divider: define MULDIV_DIV_EN to build ops 4-7; otherwise they complete as illegal.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Multiply: {partial high, multiplier/low product}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic              ill_q, ill_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_sel_q, rd_sel_d;
  logic              illegal_q, illegal_d;

  // Operand sign decode straight from funct3 at issue time.
  logic              s1, s2, neg1, neg2;
  logic [XLEN-1:0]   mag1, mag2;

  assign s1   = bus.op[2] ? ~bus.op[0] : (bus.op != 3'd3);
  assign s2   = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
  assign neg1 = s1 & bus.rs1_data[XLEN-1];
  assign neg2 = s2 & bus.rs2_data[XLEN-1];
  assign mag1 = neg1 ? (~bus.rs1_data + 1'b1) : bus.rs1_data;
  assign mag2 = neg2 ? (~bus.rs2_data + 1'b1) : bus.rs2_data;

  // One multiply step: conditionally add multiplicand into the high half, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign prod     = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign mul_res  = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
  // One restoring divide step: shift in the next dividend bit, subtract if it fits.
  logic              div_zero, div_ovf;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic              q_bit;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   div_res;

  assign div_zero = (bus.rs2_data == '0);
  assign div_ovf  = ~bus.op[0] && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                    && (bus.rs2_data == {XLEN{1'b1}});
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign q_bit    = ~rem_diff[XLEN];
  assign rem_new  = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign div_next = {rem_new, acc_q[XLEN-2:0], q_bit};
  // REM/REMU take the remainder (high half), DIV/DIVU the quotient (low half).
  assign div_sel  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign div_res  = neg_q ? (~div_sel + 1'b1) : div_sel;
`endif

  // Control state register; reset aborts any op in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      ill_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_sel_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_q     <= neg_d;
      ill_q     <= ill_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_sel_q  <= rd_sel_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and datapath update: capture in IDLE, iterate in CALC, fix up sign in FIN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_d     = neg_q;
    ill_d     = ill_q;
    done_d    = 1'b0;
    result_d  = result_q;
    rd_sel_d  = rd_sel_q;
    illegal_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          rd_d  = bus.rd_in;
          cnt_d = '0;
          ill_d = 1'b0;
          if (!bus.op[2]) begin
            opnd_d  = mag1;
            acc_d   = {{XLEN{1'b0}}, mag2};
            neg_d   = neg1 ^ neg2;
            state_d = S_CALC;
          end else begin
`ifdef MULDIV_DIV_EN
            opnd_d = mag2;
            // Remainder follows the dividend sign; quotient is negative when signs differ.
            neg_d  = bus.op[1] ? neg1 : (neg1 ^ neg2);
            if (div_zero) begin
              // Preload final values so FIN picks them like a normal divide.
              acc_d   = {bus.rs1_data, {XLEN{1'b1}}};
              neg_d   = 1'b0;
              state_d = S_FIN;
            end else if (div_ovf) begin
              acc_d   = {{XLEN{1'b0}}, bus.rs1_data};
              neg_d   = 1'b0;
              state_d = S_FIN;
            end else begin
              acc_d   = {{XLEN{1'b0}}, mag1};
              state_d = S_CALC;
            end
`else
            acc_d   = '0;
            neg_d   = 1'b0;
            ill_d   = 1'b1;
            state_d = S_FIN;
`endif
          end
        end
      end

      S_CALC: begin
`ifdef MULDIV_DIV_EN
        acc_d = op_q[2] ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        done_d    = 1'b1;
        rd_sel_d  = rd_q;
        illegal_d = ill_q;
`ifdef MULDIV_DIV_EN
        result_d  = op_q[2] ? div_res : mul_res;
`else
        result_d  = ill_q ? '0 : mul_res;
`endif
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE) || done_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.rd_sel    = rd_sel_q;
  assign bus.reg_write = done_q && (rd_sel_q != 5'd0) && !illegal_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, write-enable, abort on reset, back-to-back issue.
// Expected values are hand-computed constants.
// Divide vectors follow MULDIV_DIV_EN: real results when defined, illegal completion otherwise.
module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Issue one op, count edges to done, check the write-back fields, then check done drops.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input logic exp_ill);
    int n;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.op       = ~op;
    bus.rs1_data = ~a;
    bus.rs2_data = ~b;
    bus.rd_in    = ~rd;
    chk({tag, "_busy"}, bus.busy, 1'b1);
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_res"}, bus.result, exp_res);
    chk({tag, "_rd"}, bus.rd_sel, rd);
    chk({tag, "_wr"}, bus.reg_write, (rd != 5'd0) && !exp_ill);
    chk({tag, "_ill"}, bus.illegal, exp_ill);
    @(posedge clk);
    #1;
    chk({tag, "_done_clr"}, {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin
    int  n;
    logic seen;
    checks       = 0;
    fails        = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 3'd0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_wr", bus.reg_write, 1'b0);
    chk("rst_ill", bus.illegal, 1'b0);
    chk("rst_res", bus.result, 32'h0);
    chk("rst_rd", bus.rd_sel, 5'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, 1'b0);
    run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33, 1'b0);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33, 1'b0);
    run_op("mul_rd0", 3'd0, 32'd3,       32'd5,        5'd0,  32'd15,       33, 1'b0);
`ifdef MULDIV_DIV_EN
    run_op("divu",   3'd5, 32'd100,      32'd7,        5'd9,  32'd14,       33, 1'b0);
    run_op("remu",   3'd7, 32'd100,      32'd7,        5'd10, 32'd2,        33, 1'b0);
    run_op("div",    3'd4, 32'hFFFFFF9C, 32'd7,        5'd11, 32'hFFFFFFF2, 33, 1'b0);
    run_op("rem",    3'd6, 32'hFFFFFF9C, 32'd7,        5'd12, 32'hFFFFFFFE, 33, 1'b0);
    run_op("div_z",  3'd4, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1,  1'b0);
    run_op("rem_z",  3'd6, 32'd5,        32'd0,        5'd14, 32'd5,        1,  1'b0);
    run_op("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1,  1'b0);
    run_op("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h0,        1,  1'b0);
`else
    run_op("divu_off", 3'd5, 32'd9,      32'd3,        5'd9,  32'h0,        1,  1'b1);
    run_op("rem_off",  3'd6, 32'hFFFFFF9C, 32'd7,      5'd10, 32'h0,        1,  1'b1);
    run_op("mul_after_ill", 3'd0, 32'hFFFFFFFF, 32'd1, 5'd11, 32'hFFFFFFFF, 33, 1'b0);
`endif

    // Abort a MUL at cycle 10 with reset.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = 3'd0;
    bus.rs1_data = 32'd3;
    bus.rs2_data = 32'd4;
    bus.rd_in    = 5'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_res", bus.result, 32'h0);
    chk("abort_rd", bus.rd_sel, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.reg_write) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);
    run_op("post_abort", 3'd0, 32'd3, 32'd4, 5'd7, 32'd12, 33, 1'b0);

    // Back-to-back: start held high; second op presented while the first runs.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = 3'd0;
    bus.rs1_data = 32'd6;
    bus.rs2_data = 32'd7;
    bus.rd_in    = 5'd1;
    @(posedge clk);
    #1;
    bus.op       = 3'd3;
    bus.rs1_data = 32'hFFFFFFFF;
    bus.rs2_data = 32'hFFFFFFFF;
    bus.rd_in    = 5'd2;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_a_lat", n, 33);
    chk("b2b_a_res", bus.result, 32'd42);
    chk("b2b_a_rd", bus.rd_sel, 5'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_gap", n, 34);
    chk("b2b_b_res", bus.result, 32'hFFFFFFFE);
    chk("b2b_b_rd", bus.rd_sel, 5'd2);
    @(posedge clk);
    #1;
    chk("b2b_idle", {bus.done, bus.busy}, 2'b00);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
